// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and lane constants for the data-memory lane arbiter
package dmem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_SECOND = 1'b1
  } arb_state_t;

  localparam logic LANE_EVEN = 1'b0;
  localparam logic LANE_ODD  = 1'b1;

endpackage

// File: rtl/dmem_req_buf.sv
// rtl/dmem_req_buf.sv - one-entry {we, addr, wdata} holding buffer with load strobe and async clear
module dmem_req_buf #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          q_we,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_wdata
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_we    <= 1'b0;
      q_addr  <= '0;
      q_wdata <= '0;
    end else if (load) begin
      q_we    <= d_we;
      q_addr  <= d_addr;
      q_wdata <= d_wdata;
    end
  end

endmodule

// File: rtl/dmem_lane_arbiter.sv
// rtl/dmem_lane_arbiter.sv - EVEN/ODD lane arbiter for a single-ported data memory
// Optional same-word merge of simultaneous accesses: DMEM_ARB_MERGE_EN
module dmem_lane_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             even_req,
  input  logic             even_we,
  input  logic [AW-1:0]    even_addr,
  input  logic [DW-1:0]    even_wdata,
  output logic [DW-1:0]    even_rdata,
  input  logic             odd_req,
  input  logic             odd_we,
  input  logic [AW-1:0]    odd_addr,
  input  logic [DW-1:0]    odd_wdata,
  output logic [DW-1:0]    odd_rdata,
  output logic             stall,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [DW-1:0]    mem_wdata,
  input  logic [DW-1:0]    mem_rdata,
  output logic [CNT_W-1:0] conflict_cnt
);

  arb_state_t state, state_nxt;

  logic          both;
  logic          merge;
  logic          conflict;
  logic          sel;
  logic          lane_we;
  logic          buf_we;
  logic [AW-1:0] buf_addr;
  logic [DW-1:0] buf_wdata;
  logic [DW-1:0] even_hold;

  assign both = even_req & odd_req;

`ifdef DMEM_ARB_MERGE_EN
  // Same word and same direction: reads share data, writes let the younger lane win.
  assign merge = both && (even_addr[AW-1:2] == odd_addr[AW-1:2]) && (even_we == odd_we);
`else
  assign merge = 1'b0;
`endif

  // Gated by reset so nothing stalls or writes while reset is held.
  assign conflict = reset && (state == ARB_IDLE) && both && !merge;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:   if (conflict) state_nxt = ARB_SECOND;
      ARB_SECOND: state_nxt = ARB_IDLE;
      default:    state_nxt = ARB_IDLE;
    endcase
  end

  always_comb begin
    stall      = 1'b0;
    sel        = LANE_EVEN;
    lane_we    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    even_rdata = mem_rdata;
    odd_rdata  = mem_rdata;
    case (state)
      ARB_IDLE: begin
        stall = conflict;
        sel   = (odd_req && (!even_req || merge)) ? LANE_ODD : LANE_EVEN;
        if (sel == LANE_ODD) begin
          lane_we   = odd_we;
          mem_addr  = odd_addr;
          mem_wdata = odd_wdata;
        end else if (even_req) begin
          lane_we   = even_we;
          mem_addr  = even_addr;
          mem_wdata = even_wdata;
        end
      end
      ARB_SECOND: begin
        lane_we    = buf_we;
        mem_addr   = buf_addr;
        mem_wdata  = buf_wdata;
        even_rdata = even_hold;
      end
      default: ;
    endcase
  end

  assign mem_we = lane_we & reset;

  dmem_req_buf #(.AW(AW), .DW(DW)) u_req_buf (
    .clk     (clk),
    .reset   (reset),
    .load    (conflict),
    .d_we    (odd_we),
    .d_addr  (odd_addr),
    .d_wdata (odd_wdata),
    .q_we    (buf_we),
    .q_addr  (buf_addr),
    .q_wdata (buf_wdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        even_hold <= '0;
    else if (conflict) even_hold <= mem_rdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_cnt <= '0;
    else if (conflict && (conflict_cnt != {CNT_W{1'b1}}))
      conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_dmem_lane_arbiter.sv
// tb/tb_dmem_lane_arbiter.sv - scoreboard bench for dmem_lane_arbiter with a behavioural memory
module tb_dmem_lane_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int CNT_W = 8;
  localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

  logic             clk = 1'b0;
  logic             reset;
  logic             even_req, even_we, odd_req, odd_we;
  logic [AW-1:0]    even_addr, odd_addr;
  logic [DW-1:0]    even_wdata, odd_wdata, even_rdata, odd_rdata;
  logic             stall, mem_we;
  logic [AW-1:0]    mem_addr;
  logic [DW-1:0]    mem_wdata, mem_rdata;
  logic [CNT_W-1:0] conflict_cnt;

  logic [DW-1:0] mem [0:255];
  int wr_pulses = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr_pulses <= wr_pulses + 1;
    end
  end

  dmem_lane_arbiter #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .even_req     (even_req),
    .even_we      (even_we),
    .even_addr    (even_addr),
    .even_wdata   (even_wdata),
    .even_rdata   (even_rdata),
    .odd_req      (odd_req),
    .odd_we       (odd_we),
    .odd_addr     (odd_addr),
    .odd_wdata    (odd_wdata),
    .odd_rdata    (odd_rdata),
    .stall        (stall),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  typedef enum {S_STALL, S_WE, S_ADDR, S_WDATA, S_ERD, S_ORD, S_CNT} sig_e;
  typedef struct {
    string       tag;
    sig_e        sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] observe(input sig_e s);
    case (s)
      S_STALL: return {31'd0, stall};
      S_WE:    return {31'd0, mem_we};
      S_ADDR:  return mem_addr;
      S_WDATA: return mem_wdata;
      S_ERD:   return even_rdata;
      S_ORD:   return odd_rdata;
      default: return 32'(conflict_cnt);
    endcase
  endfunction

  // Compare everything queued for this cycle at the falling edge, then advance one cycle.
  task automatic step();
    exp_t e;
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.sig), e.val);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic er, input logic ew, input logic [31:0] ea, input logic [31:0] ed,
                       input logic orq, input logic ow, input logic [31:0] oa, input logic [31:0] od);
    even_req = er; even_we = ew; even_addr = ea; even_wdata = ed;
    odd_req = orq; odd_we = ow; odd_addr = oa; odd_wdata = od;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic even_write(input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    idle();
  endtask

  task automatic even_read_check(input string tag, input logic [31:0] a, input logic [31:0] d);
    drive(1'b1, 1'b0, a, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_sig(tag, S_ERD, d);
    step();
    idle();
  endtask

  int pulses0;
  logic [31:0] exp_cnt;

  initial begin
    reset = 1'b0;
    idle();
    expect_sig("rst_stall", S_STALL, 0);
    expect_sig("rst_we", S_WE, 0);
    expect_sig("rst_addr", S_ADDR, 0);
    expect_sig("rst_wdata", S_WDATA, 0);
    expect_sig("rst_cnt", S_CNT, 0);
    step();
    reset = 1'b1;
    expect_sig("idle_we", S_WE, 0);
    expect_sig("idle_addr", S_ADDR, 0);
    step();

    // single EVEN write passes straight through
    drive(1'b1, 1'b1, 32'h40, 32'h1234, 1'b0, 1'b0, 32'h0, 32'h0);
    expect_sig("single_we", S_WE, 1);
    expect_sig("single_addr", S_ADDR, 32'h40);
    expect_sig("single_wdata", S_WDATA, 32'h1234);
    expect_sig("single_stall", S_STALL, 0);
    step();
    idle();
    even_read_check("single_rd", 32'h40, 32'h1234);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
    expect_sig("odd_only_rd", S_ORD, 32'h1234);
    expect_sig("odd_only_stall", S_STALL, 0);
    step();

    // EVEN read + ODD write, lane inputs dropped in the second cycle
    even_write(32'h10, 32'hAA);
    drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 32'h20, 32'h55);
    expect_sig("c1_stall", S_STALL, 1);
    expect_sig("c1_addr", S_ADDR, 32'h10);
    expect_sig("c1_we", S_WE, 0);
    step();
    idle();
    expect_sig("c2_stall", S_STALL, 0);
    expect_sig("c2_addr", S_ADDR, 32'h20);
    expect_sig("c2_we", S_WE, 1);
    expect_sig("c2_wdata", S_WDATA, 32'h55);
    expect_sig("c2_erd", S_ERD, 32'hAA);
    expect_sig("c2_cnt", S_CNT, 1);
    step();
    even_read_check("c2_commit", 32'h20, 32'h55);

    // EVEN write then ODD read of the same word keeps program order
    drive(1'b1, 1'b1, 32'h30, 32'h77, 1'b1, 1'b0, 32'h30, 32'h0);
    expect_sig("wr_rd_c1_stall", S_STALL, 1);
    expect_sig("wr_rd_c1_we", S_WE, 1);
    step();
    expect_sig("wr_rd_c2_ord", S_ORD, 32'h77);
    expect_sig("wr_rd_c2_stall", S_STALL, 0);
    expect_sig("wr_rd_cnt", S_CNT, 2);
    step();
    idle();

    // both lanes read the same word
    even_write(32'h50, 32'h99);
    drive(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, 1'b0, 32'h50, 32'h0);
`ifdef DMEM_ARB_MERGE_EN
    expect_sig("rr_stall", S_STALL, 0);
    expect_sig("rr_erd", S_ERD, 32'h99);
    expect_sig("rr_ord", S_ORD, 32'h99);
    expect_sig("rr_cnt", S_CNT, 2);
    step();
`else
    expect_sig("rr_c1_stall", S_STALL, 1);
    expect_sig("rr_c1_erd", S_ERD, 32'h99);
    step();
    expect_sig("rr_c2_stall", S_STALL, 0);
    expect_sig("rr_c2_erd", S_ERD, 32'h99);
    expect_sig("rr_c2_ord", S_ORD, 32'h99);
    expect_sig("rr_cnt", S_CNT, 3);
    step();
`endif
    idle();

    // both lanes write the same word; younger data must remain
    pulses0 = wr_pulses;
    drive(1'b1, 1'b1, 32'h60, 32'h1, 1'b1, 1'b1, 32'h60, 32'h2);
`ifdef DMEM_ARB_MERGE_EN
    expect_sig("ww_stall", S_STALL, 0);
    expect_sig("ww_wdata", S_WDATA, 32'h2);
    step();
    idle();
    step();
    chk("ww_pulses", 32'(wr_pulses - pulses0), 32'd1);
`else
    expect_sig("ww_c1_stall", S_STALL, 1);
    expect_sig("ww_c1_wdata", S_WDATA, 32'h1);
    step();
    expect_sig("ww_c2_wdata", S_WDATA, 32'h2);
    step();
    idle();
    step();
    chk("ww_pulses", 32'(wr_pulses - pulses0), 32'd2);
`endif
    even_read_check("ww_final", 32'h60, 32'h2);

    // reset in ARB_SECOND discards the buffered ODD write
    even_write(32'h74, 32'h11);
    drive(1'b1, 1'b0, 32'h70, 32'h0, 1'b1, 1'b1, 32'h74, 32'hDEAD);
    expect_sig("rs_c1_stall", S_STALL, 1);
    step();
    pulses0 = wr_pulses;
    chk("rs_c2_we_before", {31'd0, mem_we}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rs_stall", {31'd0, stall}, 32'd0);
    chk("rs_we", {31'd0, mem_we}, 32'd0);
    chk("rs_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    #1;
    chk("rs_held_stall", {31'd0, stall}, 32'd0);
    reset = 1'b1;
    idle();
    step();
    chk("rs_no_write", 32'(wr_pulses - pulses0), 32'd0);
    even_read_check("rs_mem_kept", 32'h74, 32'h11);

    // counter saturation with alternating stall pattern
    exp_cnt = 0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h4, 32'(i));
      expect_sig("sat_stall_hi", S_STALL, 1);
      step();
      idle();
      exp_cnt = (exp_cnt == CNT_MAX) ? CNT_MAX : exp_cnt + 32'd1;
      expect_sig("sat_stall_lo", S_STALL, 0);
      expect_sig("sat_cnt", S_CNT, exp_cnt);
      step();
    end
    chk("sat_final", 32'(conflict_cnt), CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
